// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder.
// Optional feature macro: SERIAL_ADD_OVF_EN (signed overflow flag).
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// ovf signal exists only with SERIAL_ADD_OVF_EN defined.
interface serial_adder_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
`endif
endinterface

// File: rtl/serial_adder_fa_cell.sv
// Single combinational full-adder cell.
// Shared by every bit position of the serial adder.
module fa_cell (
  output logic s,
  output logic co,
  input  logic a,
  input  logic b,
  input  logic c
);
  // sum is parity, carry is majority
  always_comb begin
    s  = a ^ b ^ c;
    co = (a & b) | (a & c) | (b & c);
  end
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder step per clock, LSB first.
// Optional feature macro: SERIAL_ADD_OVF_EN adds the signed ovf flag.
module serial_adder
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic clk,
  input logic rst,
  serial_adder_if.slave bus
);
  localparam int CW = cnt_w(WIDTH);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] sum_sh;
  logic [WIDTH-1:0] sum_cat;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             s;
  logic             c;
  logic             last;
  logic             in_ready;
  logic             out_valid;
  logic             accept;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q;
`endif

  fa_cell u_fa (
    .s  (s),
    .co (c),
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .c  (carry)
  );

  assign last    = (cnt == CW'(WIDTH - 1));
  assign accept  = bus.in_valid && in_ready;
  assign sum_cat = {s, sum_sh};

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept)        state_nx = RUN;
      RUN:     if (last)          state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default:                    state_nx = IDLE;
    endcase
  end

  // handshake outputs decoded from state
  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE);
  end

  // operand shifters, carry, counter and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else if (state == IDLE) begin
      if (accept) begin
        a_sh  <= bus.a;
        b_sh  <= bus.b;
        carry <= bus.cin;
        cnt   <= '0;
      end
    end else if (state == RUN) begin
      a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
      sum_sh <= sum_cat[WIDTH-1:1];
      carry  <= c;
      cnt    <= cnt + 1'b1;
      if (last) begin
        sum_q  <= sum_cat;
        cout_q <= c;
`ifdef SERIAL_ADD_OVF_EN
        // carry into the MSB is the cell's carry-in on this step
        ovf_q  <= carry ^ c;
`endif
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule
